// File: rtl/cmd_issuer.sv
// Command issue stage: filters and buffers {op_code, address, data} commands in a FIFO,
// then presents them to the execution block one at a time with idle cycles between.
module cmd_issuer #(
    parameter int DEPTH    = 4,
    parameter int GAP      = 1,
    parameter int NUM_REGS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_op_code,
    input  logic [7:0]             in_address,
    input  logic [15:0]            in_data,
    output logic [7:0]             op_code,
    output logic [7:0]             address,
    output logic [15:0]            data,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            issue_cnt,
    output logic [7:0]             drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL   = (PTR_W+1)'(DEPTH);
    localparam logic [8:0]     REG_LIMIT  = 9'(NUM_REGS);
    localparam logic [3:0]     GAP_RELOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t           state;
    logic [3:0]       gap_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      fifo_mem [DEPTH];
    logic [31:0]      head;
    logic             full;
    logic             empty;
    logic             accept;
    logic             reject;
    logic             push;
    logic             pop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign reject   = (in_op_code == 8'd0) || ({1'b0, in_address} >= REG_LIMIT);
    assign push     = accept && !reject;
    assign head     = fifo_mem[rd_ptr];

    // A pop happens exactly when the FSM is about to load a new command.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = !empty;
            S_ISSUE: pop = (GAP == 0) && !empty;
            S_GAP:   pop = (gap_cnt == 4'd0) && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {in_op_code, in_address, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (accept && reject)
                drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    // address/data only move on a pop, so they hold through IDLE and GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            op_code   <= '0;
            address   <= '0;
            data      <= '0;
            issue_cnt <= '0;
        end else begin
            if (pop) begin
                op_code   <= head[31:24];
                address   <= head[23:16];
                data      <= head[15:0];
                issue_cnt <= issue_cnt + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (pop)
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (GAP > 0) begin
                        op_code <= '0;
                        gap_cnt <= GAP_RELOAD;
                        state   <= S_GAP;
                    end else if (!pop) begin
                        op_code <= '0;
                        state   <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0)
                        state <= pop ? S_ISSUE : S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 4'd1;
                end
                default: begin
                    op_code <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_issuer.sv
// Scoreboard bench for cmd_issuer: three instances (GAP 1, 0, 3), directed stimulus,
// a negedge monitor that checks issued commands, level, in_ready, hold and spacing.
module tb_cmd_issuer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid [3];
    logic        in_ready [3];
    logic [7:0]  in_op    [3];
    logic [7:0]  in_addr  [3];
    logic [15:0] in_data  [3];
    logic [7:0]  op_o     [3];
    logic [7:0]  addr_o   [3];
    logic [15:0] data_o   [3];
    logic [2:0]  lvl_o    [3];
    logic [15:0] icnt_o   [3];
    logic [7:0]  dcnt_o   [3];

    cmd_issuer #(.DEPTH(4), .GAP(1), .NUM_REGS(8)) u_gap1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_op_code(in_op[0]), .in_address(in_addr[0]), .in_data(in_data[0]),
        .op_code(op_o[0]), .address(addr_o[0]), .data(data_o[0]),
        .level(lvl_o[0]), .issue_cnt(icnt_o[0]), .drop_cnt(dcnt_o[0]));

    cmd_issuer #(.DEPTH(4), .GAP(0), .NUM_REGS(8)) u_gap0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_op_code(in_op[1]), .in_address(in_addr[1]), .in_data(in_data[1]),
        .op_code(op_o[1]), .address(addr_o[1]), .data(data_o[1]),
        .level(lvl_o[1]), .issue_cnt(icnt_o[1]), .drop_cnt(dcnt_o[1]));

    cmd_issuer #(.DEPTH(4), .GAP(3), .NUM_REGS(8)) u_gap3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_op_code(in_op[2]), .in_address(in_addr[2]), .in_data(in_data[2]),
        .op_code(op_o[2]), .address(addr_o[2]), .data(data_o[2]),
        .level(lvl_o[2]), .issue_cnt(icnt_o[2]), .drop_cnt(dcnt_o[2]));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    int exp_sp [3];
    bit have_last [3];
    int last_t [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void exp_push(int i, logic [31:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int q_size(int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void q_pop(int i, output bit ok, output logic [31:0] v);
        ok = (q_size(i) != 0);
        v = '0;
        if (ok) begin
            case (i)
                0: v = q0.pop_front();
                1: v = q1.pop_front();
                default: v = q2.pop_front();
            endcase
        end
    endfunction

    // Monitor: each negedge with op_code != 0 is one issued command.
    logic [2:0]  m_lvl  [3];
    bit          m_push [3];
    logic [7:0]  m_addr [3];
    logic [15:0] m_data [3];
    bit          m_popped;
    bit          m_ok;
    logic [2:0]  m_elvl;
    logic [31:0] m_exp;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_lvl[i]  = '0;
                m_push[i] = 1'b0;
                m_addr[i] = '0;
                m_data[i] = '0;
            end else begin
                m_popped = (op_o[i] != 8'd0);
                m_elvl = m_lvl[i] + 3'(m_push[i]) - 3'(m_popped);
                chk($sformatf("level_dut%0d", i), 32'(lvl_o[i]), 32'(m_elvl));
                chk($sformatf("in_ready_dut%0d", i), 32'(in_ready[i]), 32'(m_elvl != 3'd4));
                if (m_popped) begin
                    q_pop(i, m_ok, m_exp);
                    if (!m_ok) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_issue_dut%0d: got op 0x%0h, expected no command", i, op_o[i]);
                    end else begin
                        chk($sformatf("issue_dut%0d", i), {op_o[i], addr_o[i], data_o[i]}, m_exp);
                    end
                    if (exp_sp[i] != 0) begin
                        if (have_last[i])
                            chk($sformatf("spacing_dut%0d", i), 32'(cyc - last_t[i]), 32'(exp_sp[i]));
                        have_last[i] = 1'b1;
                        last_t[i] = cyc;
                    end
                end else begin
                    chk($sformatf("addr_hold_dut%0d", i), 32'(addr_o[i]), 32'(m_addr[i]));
                    chk($sformatf("data_hold_dut%0d", i), 32'(data_o[i]), 32'(m_data[i]));
                end
                m_lvl[i]  = m_elvl;
                m_addr[i] = addr_o[i];
                m_data[i] = data_o[i];
                m_push[i] = in_valid[i] && in_ready[i] && (in_op[i] != 8'd0) && (in_addr[i] < 8'd8);
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic push(input int i, input logic [7:0] op, input logic [7:0] ad,
                        input logic [15:0] d, input bit keep, output int stalls);
        in_op[i] = op;
        in_addr[i] = ad;
        in_data[i] = d;
        in_valid[i] = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (in_ready[i]) break;
            stalls++;
            if (stalls > 50) break;
        end
        if (stalls > 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout_dut%0d: in_ready stuck at 0, expected 1", i);
        end
        @(posedge clk);
        if (stalls <= 50 && op != 8'd0 && ad < 8'd8)
            exp_push(i, {op, ad, d});
        #1;
        if (!keep) in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int w = 0;
        while (q_size(i) != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        chk($sformatf("drain_dut%0d", i), 32'(q_size(i)), 32'd0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            exp_sp[i] = 0;
            have_last[i] = 1'b0;
        end
        rst = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int total;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_op[i] = '0;
            in_addr[i] = '0;
            in_data[i] = '0;
            exp_sp[i] = 0;
            have_last[i] = 1'b0;
            last_t[i] = 0;
        end

        // Reset values, checked while rst is still high.
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_op", 32'(op_o[i]), 32'd0);
            chk("rst_addr", 32'(addr_o[i]), 32'd0);
            chk("rst_data", 32'(data_o[i]), 32'd0);
            chk("rst_level", 32'(lvl_o[i]), 32'd0);
            chk("rst_issue_cnt", 32'(icnt_o[i]), 32'd0);
            chk("rst_drop_cnt", 32'(dcnt_o[i]), 32'd0);
            chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single command, GAP=1.
        push(0, 8'd1, 8'd2, 16'h1234, 1'b0, st);
        @(posedge clk); #1;
        chk("single_op", 32'(op_o[0]), 32'd1);
        chk("single_addr", 32'(addr_o[0]), 32'd2);
        chk("single_data", 32'(data_o[0]), 32'h1234);
        @(posedge clk); #1;
        chk("single_op_gap", 32'(op_o[0]), 32'd0);
        chk("single_addr_held", 32'(addr_o[0]), 32'd2);
        chk("single_issue_cnt", 32'(icnt_o[0]), 32'd1);
        drain(0);

        // Rejection: idle opcode and out-of-range address.
        push(0, 8'd0, 8'd1, 16'hAAAA, 1'b0, st);
        push(0, 8'd3, 8'd8, 16'hBBBB, 1'b0, st);
        push(0, 8'd4, 8'd7, 16'h00FF, 1'b0, st);
        drain(0);
        chk("reject_drop_cnt", 32'(dcnt_o[0]), 32'd2);
        chk("reject_issue_cnt", 32'(icnt_o[0]), 32'd2);

        // Gap sweep: GAP=0 (incl. identical pair) and GAP=1.
        do_reset();
        exp_sp[0] = 2;
        exp_sp[1] = 1;
        push(1, 8'd5, 8'd1, 16'h1111, 1'b1, st);
        push(1, 8'd7, 8'd3, 16'h3333, 1'b1, st);
        push(1, 8'd7, 8'd3, 16'h3333, 1'b0, st);
        push(0, 8'd5, 8'd1, 16'h1111, 1'b1, st);
        push(0, 8'd6, 8'd2, 16'h2222, 1'b1, st);
        push(0, 8'd7, 8'd3, 16'h3333, 1'b0, st);
        drain(1);
        drain(0);
        chk("sweep_issue_cnt_gap0", 32'(icnt_o[1]), 32'd3);
        chk("sweep_issue_cnt_gap1", 32'(icnt_o[0]), 32'd3);

        // Fill and burst on GAP=3: fifth push fills, sixth waits one cycle.
        exp_sp[0] = 0;
        exp_sp[1] = 0;
        exp_sp[2] = 4;
        have_last[2] = 1'b0;
        for (int k = 0; k < 5; k++)
            push(2, 8'(8'h10 + k), 8'(k), 16'(16'hC000 + k), 1'b1, st);
        chk("fill_level", 32'(lvl_o[2]), 32'd4);
        chk("fill_in_ready", 32'(in_ready[2]), 32'd0);
        push(2, 8'h15, 8'd5, 16'hC005, 1'b0, st);
        chk("fill_stall", 32'(st), 32'd1);
        drain(2);
        chk("fill_issue_cnt", 32'(icnt_o[2]), 32'd6);

        // Stream 12 with in_valid held high: pointer wrap, push+pop edges.
        do_reset();
        exp_sp[0] = 2;
        total = 0;
        for (int k = 0; k < 12; k++) begin
            push(0, 8'(k + 1), 8'(k % 8), 16'(16'hA000 + k), 1'b1, st);
            total += st;
        end
        in_valid[0] = 1'b0;
        drain(0);
        chk("stream_stalls", 32'(total), 32'd5);
        chk("stream_issue_cnt", 32'(icnt_o[0]), 32'd12);
        chk("stream_level", 32'(lvl_o[0]), 32'd0);

        // Reset while issuing with two entries queued.
        do_reset();
        for (int k = 0; k < 4; k++)
            push(0, 8'(8'h20 + k), 8'(k), 16'(16'hD000 + k), 1'b1, st);
        in_valid[0] = 1'b0;
        chk("midrst_pre_op", 32'(op_o[0]), 32'h21);
        chk("midrst_pre_level", 32'(lvl_o[0]), 32'd2);
        rst = 1'b1;
        #1;
        q0.delete();
        chk("midrst_op", 32'(op_o[0]), 32'd0);
        chk("midrst_level", 32'(lvl_o[0]), 32'd0);
        chk("midrst_addr", 32'(addr_o[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_issue_cnt", 32'(icnt_o[0]), 32'd0);
        chk("midrst_level_after", 32'(lvl_o[0]), 32'd0);
        push(0, 8'd9, 8'd5, 16'hBEEF, 1'b0, st);
        drain(0);
        chk("midrst_new_issue_cnt", 32'(icnt_o[0]), 32'd1);

        // drop_cnt saturates at 255.
        for (int k = 0; k < 260; k++)
            push(1, 8'd0, 8'd1, 16'(k), 1'b1, st);
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("drop_saturate", 32'(dcnt_o[1]), 32'd255);
        chk("drop_no_issue", 32'(icnt_o[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
